// File: rtl/board_state_ctrl.sv
// board_state_ctrl: authoritative chess game-state holder.
// Holds the 8x8 piece array, applies local and remote moves, tracks the side
// to move, forwards local moves to the link and flags king capture.
// Optional build macro: PAWN_PROMOTION_EN (pawns reaching the far rank become
// queens). Without it, pieces are copied unchanged.
//
// Handshakes:
//  - remote_valid/remote_ready: remote_valid is a level held by the link until
//    accepted; remote_ready is a combinational single-cycle strobe raised in
//    IDLE during the cycle the move is consumed (accepted or dropped). The
//    transfer happens on the clock edge where both are high.
//  - tx_valid/tx_ready: tx_valid rises with tx_packet and both stay stable
//    until the edge where tx_ready is high; tx_valid drops after that edge.
module board_state_ctrl #(
  parameter int MOVE_CNT_W = 8,
  parameter int SCREEN_W = 3,
  parameter logic [SCREEN_W-1:0] CHESS_SCREEN = SCREEN_W'(2)
) (
  input  logic                      CLOCK_50,
  input  logic                      reset_n,
  input  logic [SCREEN_W-1:0]       sys_state,
  input  logic                      player,
  input  logic                      local_moved,
  input  logic [11:0]               local_packet,
  input  logic                      remote_valid,
  input  logic [11:0]               remote_packet,
  output logic                      remote_ready,
  output logic                      tx_valid,
  output logic [11:0]               tx_packet,
  input  logic                      tx_ready,
  output logic [7:0][7:0][3:0]      stable_board,
  output logic                      curr_player,
  output logic                      won,
  output logic                      lost,
  output logic                      proto_err,
  output logic [MOVE_CNT_W-1:0]     move_count,
  output logic [1:0]                state_dbg
);

  typedef enum logic [1:0] {IDLE, APPLY, SEND, OVER} state_t;

  localparam logic [3:0] EMPTY    = 4'd15;
  localparam logic [3:0] KING_HI  = 4'd4;
  localparam logic [3:0] KING_LO  = 4'd10;

  // Starting position, indexed [y][x]; side 1 occupies rows 0..1.
  function automatic logic [7:0][7:0][3:0] init_layout();
    logic [7:0][7:0][3:0] b;
    b = '1;
    for (int x = 0; x < 8; x++) begin
      b[1][x] = 4'd0;
      b[6][x] = 4'd6;
    end
    b[0][0] = 4'd1;  b[0][1] = 4'd2;  b[0][2] = 4'd3;  b[0][3] = 4'd5;
    b[0][4] = 4'd4;  b[0][5] = 4'd3;  b[0][6] = 4'd2;  b[0][7] = 4'd1;
    b[7][0] = 4'd7;  b[7][1] = 4'd8;  b[7][2] = 4'd9;  b[7][3] = 4'd11;
    b[7][4] = 4'd10; b[7][5] = 4'd9;  b[7][6] = 4'd8;  b[7][7] = 4'd7;
    return b;
  endfunction

  state_t                 state, state_nxt;
  logic [7:0][7:0][3:0]   board;
  logic [11:0]            pkt;
  logic                   src_remote;
  logic                   in_chess;

  logic [2:0]             old_x, old_y, new_x, new_y;
  logic [3:0]             src_code, dst_code, placed_code;
  logic                   move_ok, king_hit;
  logic                   take_local, take_remote, drop_remote, send_done;

  assign in_chess = (sys_state == CHESS_SCREEN);

  assign old_x = pkt[11:9];
  assign old_y = pkt[8:6];
  assign new_x = pkt[5:3];
  assign new_y = pkt[2:0];

  assign src_code = board[old_y][old_x];
  assign dst_code = board[new_y][new_x];
  // A move is applied only if something stands on the source and it goes somewhere.
  assign move_ok  = (src_code != EMPTY) && (pkt[11:6] != pkt[5:0]);
  assign king_hit = (dst_code == KING_HI) || (dst_code == KING_LO);

  // Code written to the destination square (promotion when enabled).
  always_comb begin
    placed_code = src_code;
`ifdef PAWN_PROMOTION_EN
    if (src_code == 4'd0 && new_y == 3'd7) begin
      placed_code = 4'd5;
    end else if (src_code == 4'd6 && new_y == 3'd0) begin
      placed_code = 4'd11;
    end
`endif
  end

  // State register; leaving the chess screen parks the FSM in IDLE.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else if (!in_chess) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_nxt   = state;
    take_local  = 1'b0;
    take_remote = 1'b0;
    drop_remote = 1'b0;
    send_done   = 1'b0;
    case (state)
      IDLE: begin
        if (local_moved && (curr_player == player)) begin
          take_local = 1'b1;
          state_nxt  = APPLY;
        end else if (remote_valid && (curr_player != player)) begin
          take_remote = 1'b1;
          state_nxt   = APPLY;
        end else if (remote_valid) begin
          // Peer moved out of turn: consume and flag it.
          drop_remote = 1'b1;
        end
      end
      APPLY: begin
        if (!move_ok) begin
          state_nxt = IDLE;
        end else if (!src_remote) begin
          state_nxt = SEND;
        end else if (king_hit) begin
          state_nxt = OVER;
        end else begin
          state_nxt = IDLE;
        end
      end
      SEND: begin
        if (tx_ready) begin
          send_done = 1'b1;
          state_nxt = won ? OVER : IDLE;
        end
      end
      OVER: begin
        state_nxt = OVER;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Board, turn, flags and latched move.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      board       <= init_layout();
      curr_player <= 1'b1;
      won         <= 1'b0;
      lost        <= 1'b0;
      proto_err   <= 1'b0;
      move_count  <= '0;
      pkt         <= '0;
      src_remote  <= 1'b0;
    end else if (!in_chess) begin
      board       <= init_layout();
      curr_player <= 1'b1;
      won         <= 1'b0;
      lost        <= 1'b0;
      proto_err   <= 1'b0;
      move_count  <= '0;
      pkt         <= '0;
      src_remote  <= 1'b0;
    end else begin
      if (take_local) begin
        pkt        <= local_packet;
        src_remote <= 1'b0;
      end
      if (take_remote) begin
        pkt        <= remote_packet;
        src_remote <= 1'b1;
      end
      if (drop_remote) begin
        proto_err <= 1'b1;
      end
      if (state == APPLY) begin
        if (!move_ok) begin
          if (src_remote) begin
            proto_err <= 1'b1;
          end
        end else begin
          board[new_y][new_x] <= placed_code;
          board[old_y][old_x] <= EMPTY;
          move_count          <= move_count + MOVE_CNT_W'(1);
          if (king_hit) begin
            if (src_remote) begin
              lost <= 1'b1;
            end else begin
              won <= 1'b1;
            end
          end
          // Remote moves hand the turn back immediately; local ones wait for the link.
          if (src_remote) begin
            curr_player <= ~curr_player;
          end
        end
      end
      if (send_done) begin
        curr_player <= ~curr_player;
      end
    end
  end

  assign remote_ready = reset_n && in_chess && (take_remote || drop_remote);
  assign tx_valid     = (state == SEND);
  assign tx_packet    = tx_valid ? pkt : 12'd0;
  assign stable_board = board;
  assign state_dbg    = state;

endmodule

// File: tb/tb_board_state_ctrl.sv
// tb_board_state_ctrl: directed and randomized checks of board_state_ctrl
// against a square-by-square game model.
module tb_board_state_ctrl;

  localparam logic [2:0] CHESS = 3'd2;

  // ---------------- clock / reset ----------------
  logic                 CLOCK_50 = 1'b0;
  logic                 reset_n = 1'b0;
  logic [2:0]           sys_state = CHESS;
  logic                 player = 1'b1;
  logic                 local_moved = 1'b0;
  logic [11:0]          local_packet = '0;
  logic                 remote_valid = 1'b0;
  logic [11:0]          remote_packet = '0;
  logic                 remote_ready;
  logic                 tx_valid;
  logic [11:0]          tx_packet;
  logic                 tx_ready = 1'b0;
  logic [7:0][7:0][3:0] stable_board;
  logic                 curr_player, won, lost, proto_err;
  logic [7:0]           move_count;
  logic [1:0]           state_dbg;

  always #5 CLOCK_50 = ~CLOCK_50;

  board_state_ctrl dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .sys_state(sys_state), .player(player),
    .local_moved(local_moved), .local_packet(local_packet),
    .remote_valid(remote_valid), .remote_packet(remote_packet), .remote_ready(remote_ready),
    .tx_valid(tx_valid), .tx_packet(tx_packet), .tx_ready(tx_ready),
    .stable_board(stable_board), .curr_player(curr_player), .won(won), .lost(lost),
    .proto_err(proto_err), .move_count(move_count), .state_dbg(state_dbg)
  );

  // ---------------- reference model ----------------
  int  ref_b [8][8];
  bit  ref_turn, ref_won, ref_lost, ref_perr, ref_over;
  int  ref_cnt;
  int  back_row [8] = '{1, 2, 3, 5, 4, 3, 2, 1};

  function automatic void ref_reset();
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++) ref_b[y][x] = 15;
    for (int x = 0; x < 8; x++) begin
      ref_b[0][x] = back_row[x];
      ref_b[1][x] = 0;
      ref_b[6][x] = 6;
      ref_b[7][x] = back_row[x] + 6;
    end
    ref_turn = 1'b1; ref_won = 1'b0; ref_lost = 1'b0; ref_perr = 1'b0; ref_over = 1'b0;
    ref_cnt = 0;
  endfunction

  // Returns 1 if the move changed the board.
  function automatic bit ref_apply(input logic [11:0] p, input bit remote);
    int ox, oy, nx, ny, piece, victim;
    ox = int'(p[11:9]); oy = int'(p[8:6]); nx = int'(p[5:3]); ny = int'(p[2:0]);
    if (ref_b[oy][ox] == 15 || (ox == nx && oy == ny)) return 1'b0;
    piece  = ref_b[oy][ox];
    victim = ref_b[ny][nx];
`ifdef PAWN_PROMOTION_EN
    if (piece == 0 && ny == 7) piece = 5;
    if (piece == 6 && ny == 0) piece = 11;
`endif
    ref_b[ny][nx] = piece;
    ref_b[oy][ox] = 15;
    ref_cnt = (ref_cnt + 1) % 256;
    if (victim == 4 || victim == 10) begin
      if (remote) ref_lost = 1'b1;
      else        ref_won  = 1'b1;
    end
    return 1'b1;
  endfunction

  // ---------------- scoreboard ----------------
  logic [11:0] exp_q [$];     // packets expected on tx handshakes
  logic [0:0]  exp_rr_q [$];  // curr_player expected at each remote_ready strobe
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0d with nothing expected", name, act);
  endtask

  task automatic check_board(input string tag);
    int bad = 0;
    int by = 0;
    int bx = 0;
    for (int y = 0; y < 8; y++)
      for (int x = 0; x < 8; x++)
        if (stable_board[y][x] !== 4'(ref_b[y][x])) begin
          if (bad == 0) begin by = y; bx = x; end
          bad++;
        end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL board_%s: [%0d][%0d] got %0d want %0d (%0d squares differ)",
               tag, by, bx, stable_board[by][bx], ref_b[by][bx], bad);
    end
  endtask

  task automatic check_state(input string tag);
    check_board(tag);
    chk({"curr_player_", tag}, curr_player, ref_turn);
    chk({"won_", tag}, won, ref_won);
    chk({"lost_", tag}, lost, ref_lost);
    chk({"proto_err_", tag}, proto_err, ref_perr);
    chk({"move_count_", tag}, move_count, ref_cnt);
    chk({"tx_valid_", tag}, tx_valid, 0);
  endtask

  // Monitor: pops expectations whenever the DUT presents a transfer.
  initial begin
    logic [11:0] e;
    logic [0:0]  r;
    forever begin
      @(negedge CLOCK_50);
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) fail_evt("tx_unexpected", tx_packet);
        else begin
          e = exp_q.pop_front();
          chk("tx_packet_handshake", tx_packet, e);
        end
      end
      if (remote_ready) begin
        if (exp_rr_q.size() == 0) fail_evt("remote_ready_unexpected", curr_player);
        else begin
          r = exp_rr_q.pop_front();
          chk("remote_ready_turn", curr_player, r);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // hold < 0 picks a random number of tx_ready-low cycles.
  task automatic do_local(input logic [11:0] p, input int hold);
    bit moved = 1'b0;
    int k;
    if (!ref_over && ref_turn == player) moved = ref_apply(p, 1'b0);
    if (moved) exp_q.push_back(p);
    tick(); local_moved = 1'b1; local_packet = p;
    tick(); local_moved = 1'b0;
    tick();
    if (moved) begin
      chk("tx_valid_latency", tx_valid, 1);
      check_board("after_apply");
      k = (hold < 0) ? $urandom_range(0, 4) : hold;
      for (int i = 0; i < k; i++) begin
        tick();
        chk("tx_valid_hold", tx_valid, 1);
        chk("tx_packet_hold", tx_packet, p);
      end
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      ref_turn = ~ref_turn;
      if (ref_won) ref_over = 1'b1;
    end
    check_state("local");
  endtask

  task automatic do_remote(input logic [11:0] p);
    bit expect_rr = !ref_over;
    bit seen = 1'b0;
    if (expect_rr) begin
      exp_rr_q.push_back(ref_turn);
      if (ref_turn == player) ref_perr = 1'b1;
      else if (!ref_apply(p, 1'b1)) ref_perr = 1'b1;
      else begin
        ref_turn = ~ref_turn;
        if (ref_lost) ref_over = 1'b1;
      end
    end
    tick(); remote_valid = 1'b1; remote_packet = p;
    for (int i = 0; i < 6 && !seen; i++) begin
      @(negedge CLOCK_50);
      if (remote_ready) seen = 1'b1;
    end
    tick(); remote_valid = 1'b0;
    chk("remote_ready_seen", seen, expect_rr);
    tick();
    check_state("remote");
  endtask

  task automatic screen_reset(input logic new_player);
    tick(); sys_state = 3'd0; player = new_player;
    tick();
    tick();
    chk("off_screen_tx_valid", tx_valid, 0);
    chk("off_screen_curr_player", curr_player, 1);
    sys_state = CHESS;
    ref_reset();
    tick();
    check_state("screen_reset");
  endtask

  function automatic logic [11:0] rand_move();
    logic [2:0] ox, oy, nx, ny;
    ox = 3'($urandom_range(0, 7));
    oy = 3'($urandom_range(0, 7));
    if ($urandom_range(0, 9) != 0) begin
      for (int t = 0; t < 20 && ref_b[oy][ox] == 15; t++) begin
        ox = 3'($urandom_range(0, 7));
        oy = 3'($urandom_range(0, 7));
      end
    end
    nx = 3'($urandom_range(0, 7));
    ny = 3'($urandom_range(0, 7));
    return {ox, oy, nx, ny};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int r;
    ref_reset();
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("reset_remote_ready", remote_ready, 0);
    reset_n = 1'b1;
    tick();
    for (int x = 0; x < 8; x++) chk("reset_row0", stable_board[0][x], back_row[x]);
    chk("reset_sq_1_4", stable_board[1][4], 0);
    chk("reset_sq_3_3", stable_board[3][3], 15);
    check_state("reset");

    // Local pawn push with a stalled link.
    do_local({3'd4, 3'd1, 3'd4, 3'd3}, 5);
    chk("sq_3_4", stable_board[3][4], 0);
    chk("sq_1_4", stable_board[1][4], 15);
    chk("turn_after_local", curr_player, 0);
    chk("count_after_local", move_count, 1);

    // Remote reply.
    do_remote({3'd3, 3'd6, 3'd3, 3'd4});
    chk("sq_4_3", stable_board[4][3], 6);
    chk("turn_after_remote", curr_player, 1);

    // Remote move out of turn.
    do_remote({3'd0, 3'd6, 3'd0, 3'd5});
    chk("proto_err_out_of_turn", proto_err, 1);

    // Capture the opposing king, then everything is ignored.
    screen_reset(1'b1);
    do_local({3'd3, 3'd0, 3'd4, 3'd7}, 2);
    chk("won_king", won, 1);
    chk("state_over", state_dbg, 3);
    do_local({3'd0, 3'd1, 3'd0, 3'd2}, 0);
    do_remote({3'd0, 3'd6, 3'd0, 3'd5});
    chk("over_frozen_count", move_count, 1);

    // Pawn reaching the last rank.
    screen_reset(1'b1);
    do_local({3'd2, 3'd1, 3'd2, 3'd6}, 0);
    do_remote({3'd0, 3'd6, 3'd0, 3'd5});
    do_local({3'd2, 3'd6, 3'd2, 3'd7}, 1);
`ifdef PAWN_PROMOTION_EN
    chk("promotion_sq_7_2", stable_board[7][2], 5);
`else
    chk("promotion_sq_7_2", stable_board[7][2], 0);
`endif

    // Reset while the local move is being offered.
    screen_reset(1'b1);
    tick(); local_moved = 1'b1; local_packet = {3'd4, 3'd1, 3'd4, 3'd3};
    tick(); local_moved = 1'b0;
    tick();
    chk("abort_tx_valid_up", tx_valid, 1);
    tick();
    reset_n = 1'b0;
    #1;
    chk("abort_tx_valid_drop", tx_valid, 0);
    chk("abort_curr_player", curr_player, 1);
    tick();
    reset_n = 1'b1;
    ref_reset();
    tick();
    check_state("abort");

    // Randomized game traffic.
    for (int i = 0; i < 160; i++) begin
      r = $urandom_range(0, 19);
      if (ref_over && $urandom_range(0, 2) == 0) r = 19;
      if (r < 9)       do_local(rand_move(), -1);
      else if (r < 18) do_remote(rand_move());
      else             screen_reset(1'($urandom_range(0, 1)));
    end

    tick();
    tick();
    chk("tx_queue_drained", exp_q.size(), 0);
    chk("rr_queue_drained", exp_rr_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/board_state_ctrl.md
Name: board_state_ctrl

Overview:
Authoritative game-state holder directly downstream of the move-selection board block.
- Owns the 8x8 piece array driven out as stable_board.
- Applies committed local moves (moved pulse + 12-bit move packet) and remote moves (from the link interface).
- Toggles curr_player after each applied move, forwards local moves to the link transmitter, and flags king capture.

Parameters:
- MOVE_CNT_W, 8, width of the applied-move counter.

Ports:
- CLOCK_50  in  1  system clock
- reset_n  in  1  async active-low reset
- sys_state  in  screen_state_t  top-level screen state; board active only in CHESS_SCREEN
- player  in  1  this station's side (1 = pieces 0..5, 0 = pieces 6..11)
- local_moved  in  1  one-cycle pulse: local move validated
- local_packet  in  12  {old_x[11:9], old_y[8:6], new_x[5:3], new_y[2:0]}
- remote_valid  in  1  remote move available (level until accepted)
- remote_packet  in  12  same format as local_packet
- remote_ready  out  1  one-cycle accept strobe for remote move
- tx_valid  out  1  local move offered to link
- tx_packet  out  12  move being transmitted
- tx_ready  in  1  link accepts tx_packet
- stable_board  out  4 x [8][8]  piece codes; 15 = empty
- curr_player  out  1  side to move
- won  out  1  sticky: this station captured opposing king
- lost  out  1  sticky: own king captured
- proto_err  out  1  sticky: out-of-turn or malformed remote move seen
- move_count  out  MOVE_CNT_W  applied moves, wraps

Behaviour:
- Codes: 0 pawn, 1 rook, 2 knight, 3 bishop, 4 king, 5 queen; side 0 uses code+6; 15 empty.
- Initial layout:
  - row0 = {1,2,3,5,4,3,2,1}; row1 all 0
  - rows2..5 all 15
  - row6 all 6; row7 = {7,8,9,11,10,9,8,7}
  - Indexing is [y][x].
- Reset, and every cycle while sys_state != CHESS_SCREEN, forces:
  - initial layout, curr_player=1, state IDLE
  - all outputs 0, won/lost/proto_err cleared, move_count=0
- FSM states: IDLE, APPLY, SEND, OVER.
- IDLE:
  - local_moved && curr_player==player: latch local_packet, src=LOCAL, go APPLY.
  - else if remote_valid && curr_player!=player: latch remote_packet, pulse remote_ready, src=REMOTE, go APPLY.
  - remote_valid while curr_player==player: pulse remote_ready (drop), set proto_err, stay IDLE.
  - local_moved out of turn: ignored.
  - local_moved and remote_valid in the same cycle: only the one matching the turn rule is taken.
- APPLY (one cycle):
  - Source square empty, or old==new: no board change, no toggle. Remote source sets proto_err. Go IDLE.
  - Otherwise: board[new_y][new_x] <= board[old_y][old_x]; board[old_y][old_x] <= 15; move_count+1.
  - Captured code 4 or 10: set won (src LOCAL) or lost (src REMOTE).
  - Next state: LOCAL -> SEND; REMOTE -> toggle curr_player, then OVER if king captured else IDLE.
- SEND:
  - tx_valid=1, tx_packet = latched packet, both stable until the cycle tx_ready=1.
  - On that handshake: tx_valid drops next cycle, curr_player toggles, go OVER if won else IDLE.
- OVER: board frozen; all inputs ignored; leaves only via reset or sys_state change.
- Latency: local_moved sampled at edge N -> stable_board updated after edge N+1 -> tx_valid high after edge N+1. Minimum turn handoff is 3 cycles with tx_ready tied high.
- stable_board, curr_player and all flags are registered outputs.
- reset_n asserted mid-SEND aborts the transmit with no toggle.

Optional Feature:
- Macro PAWN_PROMOTION_EN.
- Defined: in APPLY, code 0 landing on new_y==7 is written as 5, and code 6 landing on new_y==0 is written as 11. tx_packet is unchanged; the remote peer applies the same rule.
- Undefined: the piece code is copied unchanged.

Test Plan:
- Reset, sys_state=CHESS_SCREEN -> row0={1,2,3,5,4,3,2,1}, [1][4]=0, [3][3]=15, curr_player=1, tx_valid=0.
- player=1, local_moved with packet {x4,y1,x4,y3} -> [3][4]=0, [1][4]=15 two cycles later; tx_valid held with tx_ready=0 for 5 cycles, tx_packet stable; tx_ready=1 -> curr_player=0, move_count=1.
- player=1, curr_player=0, remote_valid {x3,y6,x3,y4} -> one remote_ready pulse, [4][3]=6, curr_player=1, tx_valid stays 0.
- Remote move while curr_player==player -> remote_ready pulse, proto_err=1, board unchanged.
- Local move landing on a square holding 10 -> won=1 after handshake, state OVER, later local_moved/remote_valid ignored.
- With PAWN_PROMOTION_EN, local move of 0 from [6][2] to [7][2] -> [7][2]=5; without the macro -> [7][2]=0.
